euler_update_engine: RTL

Fixed-step explicit Euler update stage for the ODE solver datapath. When started by the Step module's `Euler_Enable`, it walks a state vector in RAM and computes x[i] ← x[i] + h·f[i] in signed Q(DATA_WIDTH−FRAC_BITS).FRAC_BITS fixed point. It writes each result back in place and returns `Euler_End` to the Step module when the whole vector is committed. It sits directly downstream of the Step module and shares the coordinator's two-read/one-write RAM.

---
 rtl/euler_update_engine.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/euler_update_engine.sv
// Explicit Euler update stage: walks x[] and f[] in the shared RAM and writes
// x[i] <= sat(x[i] + sat((h * f[i]) >>> FRAC_BITS)) back in place, 3 cycles per element.
module euler_update_engine #(
    parameter int RAM_ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH        = 64,
    parameter int FRAC_BITS         = 32
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                Euler_Enable,
    input  logic signed [DATA_WIDTH-1:0]        Step_Size,
    input  logic        [RAM_ADDRESS_WIDTH-1:0] Vector_Length,
    input  logic        [RAM_ADDRESS_WIDTH-1:0] X_Base,
    input  logic        [RAM_ADDRESS_WIDTH-1:0] F_Base,
    output logic        [RAM_ADDRESS_WIDTH-1:0] RAM_RD1_Address,
    input  logic signed [DATA_WIDTH-1:0]        RAM_RD1_Data,
    output logic        [RAM_ADDRESS_WIDTH-1:0] RAM_RD2_Address,
    input  logic signed [DATA_WIDTH-1:0]        RAM_RD2_Data,
    output logic        [RAM_ADDRESS_WIDTH-1:0] RAM_WR_Address,
    output logic signed [DATA_WIDTH-1:0]        RAM_WR_Data,
    output logic                                Memory_WR_Enable,
    output logic                                Busy,
    output logic                                Euler_End
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MUL   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    // Drop the fractional bits (floor) and clamp the full product into DATA_WIDTH.
    function automatic logic signed [DATA_WIDTH-1:0] sat_scale(
        input logic signed [PROD_WIDTH-1:0] prod
    );
        logic signed [PROD_WIDTH-1:0] shifted;
        logic        [DATA_WIDTH:0]   upper;
        logic signed [DATA_WIDTH-1:0] result;
        shifted = prod >>> FRAC_BITS;
        upper   = shifted[PROD_WIDTH-1:DATA_WIDTH-1];
        if ((&upper) || !(|upper)) begin
            result = shifted[DATA_WIDTH-1:0];
        end else if (shifted[PROD_WIDTH-1]) begin
            result = SAT_MIN;
        end else begin
            result = SAT_MAX;
        end
        return result;
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sat_add(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic signed [DATA_WIDTH:0]   sum;
        logic signed [DATA_WIDTH-1:0] result;
        sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
            result = sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            result = sum[DATA_WIDTH-1:0];
        end
        return result;
    endfunction

    logic signed [DATA_WIDTH-1:0]        h_r;
    logic        [RAM_ADDRESS_WIDTH-1:0] n_r;
    logic        [RAM_ADDRESS_WIDTH-1:0] x_base_r;
    logic        [RAM_ADDRESS_WIDTH-1:0] f_base_r;
    logic        [RAM_ADDRESS_WIDTH-1:0] idx;
    logic        [RAM_ADDRESS_WIDTH-1:0] rd1_hold;
    logic        [RAM_ADDRESS_WIDTH-1:0] rd2_hold;
    logic        [RAM_ADDRESS_WIDTH-1:0] x_addr;
    logic        [RAM_ADDRESS_WIDTH-1:0] f_addr;
    logic                                last_elem;

    logic signed [PROD_WIDTH-1:0]        h_ext_p0;
    logic signed [PROD_WIDTH-1:0]        f_ext_p0;
    logic signed [PROD_WIDTH-1:0]        prod_p0;
    logic signed [DATA_WIDTH-1:0]        x_p1;
    logic signed [DATA_WIDTH-1:0]        scaled_p1;

    // Address arithmetic wraps naturally at RAM_ADDRESS_WIDTH bits.
    assign x_addr    = x_base_r + idx;
    assign f_addr    = f_base_r + idx;
    assign last_elem = (idx == n_r - 1'b1);

    assign h_ext_p0 = {{DATA_WIDTH{h_r[DATA_WIDTH-1]}}, h_r};
    assign f_ext_p0 = {{DATA_WIDTH{RAM_RD2_Data[DATA_WIDTH-1]}}, RAM_RD2_Data};
    assign prod_p0  = h_ext_p0 * f_ext_p0;

    // Control state: FSM, element index and the held read addresses.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            idx      <= '0;
            rd1_hold <= '0;
            rd2_hold <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (Euler_Enable) begin
                        idx <= '0;
                    end
                end
                READ: begin
                    rd1_hold <= x_addr;
                    rd2_hold <= f_addr;
                end
                WRITE: begin
                    if (!last_elem) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath registers: start-time captures and the MUL-stage operands.
    always_ff @(posedge CLK) begin
        if (state == IDLE && Euler_Enable) begin
            h_r      <= Step_Size;
            n_r      <= Vector_Length;
            x_base_r <= X_Base;
            f_base_r <= F_Base;
        end
        if (state == MUL) begin
            x_p1      <= RAM_RD1_Data;
            scaled_p1 <= sat_scale(prod_p0);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (Euler_Enable) begin
                    next_state = (Vector_Length == '0) ? DONE : READ;
                end
            end
            READ:    next_state = MUL;
            MUL:     next_state = WRITE;
            WRITE:   next_state = last_elem ? DONE : READ;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A reset landing on a WRITE cycle suppresses that element's strobe.
    always_comb begin
        Busy             = (state != IDLE);
        Euler_End        = (state == DONE);
        Memory_WR_Enable = 1'b0;
        RAM_WR_Address   = '0;
        RAM_WR_Data      = '0;
        RAM_RD1_Address  = rd1_hold;
        RAM_RD2_Address  = rd2_hold;
        case (state)
            READ: begin
                RAM_RD1_Address = x_addr;
                RAM_RD2_Address = f_addr;
            end
            WRITE: begin
                Memory_WR_Enable = RST;
                RAM_WR_Address   = x_addr;
                RAM_WR_Data      = sat_add(x_p1, scaled_p1);
            end
            default: begin
            end
        endcase
    end

endmodule
